// File: rtl/timing_rec_pkg.sv
// Shared constants and helpers for the symbol-timing recovery blocks.
package timing_rec_pkg;

   // Early capture always happens on the first tick of a symbol.
   localparam int PH_E = 0;

   // Oversampling ratios the capture-phase layout supports.
   function automatic bit osr_is_legal(input int osr);
      return (osr == 4) || (osr == 8) || (osr == 16);
   endfunction

   // Prompt capture phase, a quarter symbol in.
   function automatic int ph_p(input int osr);
      return osr / 4;
   endfunction

   // Late capture phase, half a symbol in.
   function automatic int ph_l(input int osr);
      return osr / 2;
   endfunction

   // Width of the phase counter.
   function automatic int phw(input int osr);
      return $clog2(osr);
   endfunction

endpackage

// File: rtl/els_channel.sv
// One channel of the early/prompt/late sampler: stage registers,
// aligned output registers and the early-minus-late error.
module els_channel
   import timing_rec_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk4,
   input  logic         reset,
   input  logic         cap_e,
   input  logic         cap_p,
   input  logic         cap_l,
   input  logic [W-1:0] x,
   output logic [W-1:0] s_e,
   output logic [W-1:0] s_p,
   output logic [W-1:0] s_l,
   output logic [W:0]   err
);

   logic [W-1:0] e_stage_q, e_stage_d;
   logic [W-1:0] p_stage_q, p_stage_d;
   logic [W-1:0] s_e_q, s_e_d;
   logic [W-1:0] s_p_q, s_p_d;
   logic [W-1:0] s_l_q, s_l_d;
   logic [W:0]   err_q, err_d;

   // Stage early/prompt, then publish the whole set on the late capture.
   always_comb begin
      // NOTE: every _d takes its held value first, so no path leaves it unassigned and no latch is inferred.
      e_stage_d = e_stage_q;
      p_stage_d = p_stage_q;
      s_e_d     = s_e_q;
      s_p_d     = s_p_q;
      s_l_d     = s_l_q;
      err_d     = err_q;
      if (cap_e) e_stage_d = x;
      if (cap_p) p_stage_d = x;
      if (cap_l) begin
         s_l_d = x;
         s_e_d = e_stage_q;
         s_p_d = p_stage_q;
         err_d = {e_stage_q[W-1], e_stage_q} - {x[W-1], x};
      end
   end

   // Channel registers; reset also drops any half-captured symbol.
   always_ff @(posedge clk4) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         e_stage_q <= '0;
         p_stage_q <= '0;
         s_e_q     <= '0;
         s_p_q     <= '0;
         s_l_q     <= '0;
         err_q     <= '0;
      end else begin
         e_stage_q <= e_stage_d;
         p_stage_q <= p_stage_d;
         s_e_q     <= s_e_d;
         s_p_q     <= s_p_d;
         s_l_q     <= s_l_d;
         err_q     <= err_d;
      end
   end

   assign s_e = s_e_q;
   assign s_p = s_p_q;
   assign s_l = s_l_q;
   assign err = err_q;

endmodule

// File: rtl/early_late_sampler.sv
// Multi-channel early/prompt/late symbol sampler with one-tick
// advance/retard of the sampling phase per symbol.
module early_late_sampler
   import timing_rec_pkg::*;
#(
   parameter int W   = 16,
   parameter int OSR = 4,
   parameter int CH  = 2
) (
   input  logic                    clk4,
   input  logic                    reset,
   input  logic [CH*W-1:0]         x_in,
   input  logic                    adv,
   input  logic                    ret,
   output logic [CH*W-1:0]         s_e,
   output logic [CH*W-1:0]         s_p,
   output logic [CH*W-1:0]         s_l,
   output logic [CH*(W+1)-1:0]     err,
   output logic                    sym_valid,
   output logic [$clog2(OSR)-1:0]  phase
);

   localparam int PW = phw(OSR);
   localparam logic [PW-1:0] CNT_E   = PW'(PH_E);
   localparam logic [PW-1:0] CNT_P   = PW'(ph_p(OSR));
   localparam logic [PW-1:0] CNT_L   = PW'(ph_l(OSR));
   localparam logic [PW-1:0] CNT_ADV = PW'(OSR - 2);
   localparam logic [PW-1:0] CNT_END = PW'(OSR - 1);

   if (!osr_is_legal(OSR)) begin : g_bad_osr
      $error("early_late_sampler: OSR must be 4, 8 or 16");
   end

   logic [PW-1:0] cnt_q, cnt_d;
   logic          adv_p_q, adv_p_d;
   logic          ret_p_q, ret_p_d;
   logic          held_q, held_d;      // last edge was a retard hold
   logic          sym_valid_q, sym_valid_d;
   logic          cap_e, cap_p, cap_l;

   assign cap_e = (cnt_q == CNT_E);
   assign cap_p = (cnt_q == CNT_P);
   assign cap_l = (cnt_q == CNT_L);

   // Phase counter with pending advance/retard requests; a pulse on the
   // edge that consumes its flag re-arms it for the next symbol.
   always_comb begin
      cnt_d       = (cnt_q == CNT_END) ? '0 : cnt_q + 1'b1;
      adv_p_d     = adv_p_q | adv;
      ret_p_d     = ret_p_q | ret;
      held_d      = 1'b0;
      sym_valid_d = cap_l;
      if (cnt_q == CNT_ADV) begin
         if (adv_p_q && ret_p_q) begin
            adv_p_d = adv;
            ret_p_d = ret;
         end else if (adv_p_q) begin
            cnt_d   = '0;
            adv_p_d = adv;
         end
      end
      // The second tick at the last phase must not hold again.
      if (cnt_q == CNT_END && ret_p_q && !held_q) begin
         cnt_d   = cnt_q;
         ret_p_d = ret;
         held_d  = 1'b1;
      end
   end

   // Timing-control registers.
   always_ff @(posedge clk4) begin
      if (!reset) begin
         cnt_q       <= '0;
         adv_p_q     <= 1'b0;
         ret_p_q     <= 1'b0;
         held_q      <= 1'b0;
         sym_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         adv_p_q     <= adv_p_d;
         ret_p_q     <= ret_p_d;
         held_q      <= held_d;
         sym_valid_q <= sym_valid_d;
      end
   end

   assign phase     = cnt_q;
   assign sym_valid = sym_valid_q;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      els_channel #(.W(W)) u_ch (
         .clk4  (clk4),
         .reset (reset),
         .cap_e (cap_e),
         .cap_p (cap_p),
         .cap_l (cap_l),
         .x     (x_in[c*W +: W]),
         .s_e   (s_e[c*W +: W]),
         .s_p   (s_p[c*W +: W]),
         .s_l   (s_l[c*W +: W]),
         .err   (err[c*(W+1) +: (W+1)])
      );
   end

endmodule
